cpu_ctrl_fsm: RTL and testbench

Multi-cycle control sequencer for the CPU core. It steps each instruction through fetch, decode, execute, memory and write-back, and drives the datapath selects and write enables. This includes the immediate-format select consumed by the immediate generator. It supports ADDI, LW, SW and BEQ, runs a shared instruction/data memory port through a req/ready handshake, and halts with a fault cause on an illegal opcode or a memory timeout.

---
 rtl/cpu_pkg.sv | 40 ++++
 rtl/cpu_op_decode.sv | 37 +++
 rtl/cpu_ctrl_fsm.sv | 196 +++++++++++++++++++
 tb/tb_cpu_ctrl_fsm.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the multi-cycle CPU control path.
//   - RV32 opcode / funct3 constants for the supported subset (ADDI, LW, SW, BEQ)
//   - state_t   : control sequencer states
//   - imm_sel_t : immediate-format select, encoded to match the immediate generator
//   - fault_t   : halt cause reported on the fault output
package cpu_pkg;

    localparam logic [6:0] OpcOpImm  = 7'b0010011;
    localparam logic [6:0] OpcLoad   = 7'b0000011;
    localparam logic [6:0] OpcStore  = 7'b0100011;
    localparam logic [6:0] OpcBranch = 7'b1100011;

    localparam logic [2:0] F3Addi = 3'b000;
    localparam logic [2:0] F3Lw   = 3'b010;
    localparam logic [2:0] F3Sw   = 3'b010;
    localparam logic [2:0] F3Beq  = 3'b000;

    typedef enum logic [2:0] {
        StFetch,
        StDecode,
        StExec,
        StMem,
        StWb,
        StBranch,
        StHalt
    } state_t;

    typedef enum logic [1:0] {
        ImmI = 2'd0,
        ImmS = 2'd1,
        ImmB = 2'd2
    } imm_sel_t;

    typedef enum logic [1:0] {
        FaultNone    = 2'd0,
        FaultIllegal = 2'd1,
        FaultTimeout = 2'd2
    } fault_t;

endpackage

// File: rtl/cpu_op_decode.sv
// Combinational opcode decoder for the supported instruction subset.
// Ports:
//   instr    in  32 : instruction register contents
//   is_addi  out 1  : ADDI
//   is_lw    out 1  : LW
//   is_sw    out 1  : SW
//   is_beq   out 1  : BEQ
//   illegal  out 1  : none of the above
// At most one of is_addi/is_lw/is_sw/is_beq is set; illegal is set when none is.
module cpu_op_decode
    import cpu_pkg::*;
(
    input  logic [31:0] instr,
    output logic        is_addi,
    output logic        is_lw,
    output logic        is_sw,
    output logic        is_beq,
    output logic        illegal
);

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       unused_instr;

    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];

    // Operand and immediate fields are consumed by the datapath, not here.
    assign unused_instr = ^{instr[31:15], instr[11:7]};

    assign is_addi = (opcode == OpcOpImm)  && (funct3 == F3Addi);
    assign is_lw   = (opcode == OpcLoad)   && (funct3 == F3Lw);
    assign is_sw   = (opcode == OpcStore)  && (funct3 == F3Sw);
    assign is_beq  = (opcode == OpcBranch) && (funct3 == F3Beq);
    assign illegal = !(is_addi || is_lw || is_sw || is_beq);

endmodule

// File: rtl/cpu_ctrl_fsm.sv
// Multi-cycle control sequencer: FETCH -> DECODE -> EXEC -> MEM -> WB (or BRANCH),
// driving datapath selects and write enables, with a req/ready shared memory port.
// Ports:
//   clk, rst_n     : core clock (rising edge), async active-low reset
//   instr          : IR contents, valid from DECODE onward
//   alu_zero       : ALU result is zero (used in BRANCH)
//   mem_ready      : memory completes the current request this cycle
//   mem_req/mem_we/addr_sel       : memory request, store, address select (0 PC, 1 ALU-out)
//   ir_we/mdr_we/aluout_we/reg_we : register write strobes
//   alu_src_b/alu_sub/imm_sel     : ALU operand B select, subtract, immediate format
//   wb_sel                        : write-back source (0 ALU-out, 1 MDR)
//   pc_we/pc_sel                  : PC update, PC source (0 PC+4, 1 PC+imm_b)
//   retire         : one-cycle pulse when an instruction completes
//   halted/fault   : core stopped, sticky fault cause (1 illegal, 2 memory timeout)
module cpu_ctrl_fsm
    import cpu_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] instr,
    input  logic        alu_zero,
    input  logic        mem_ready,
    output logic        mem_req,
    output logic        mem_we,
    output logic        addr_sel,
    output logic        ir_we,
    output logic        mdr_we,
    output logic        alu_src_b,
    output logic        alu_sub,
    output logic        aluout_we,
    output logic [1:0]  imm_sel,
    output logic        reg_we,
    output logic        wb_sel,
    output logic        pc_we,
    output logic        pc_sel,
    output logic        retire,
    output logic        halted,
    output logic [1:0]  fault
);

    localparam logic [7:0] TermCnt = 8'(MEM_TIMEOUT - 1);

    state_t     state_q, state_d;
    fault_t     fault_q, fault_d;
    logic [7:0] cnt_q, cnt_d;

    logic is_addi, is_lw, is_sw, is_beq, illegal;
    logic in_access;
    logic timeout;

    cpu_op_decode u_decode (
        .instr   (instr),
        .is_addi (is_addi),
        .is_lw   (is_lw),
        .is_sw   (is_sw),
        .is_beq  (is_beq),
        .illegal (illegal)
    );

    assign in_access = (state_q == StFetch) || (state_q == StMem);
    // A ready on the terminal-count cycle takes priority over the timeout.
    assign timeout   = (cnt_q == TermCnt) && !mem_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StFetch;
            fault_q <= FaultNone;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            fault_q <= fault_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        fault_d   = fault_q;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        addr_sel  = 1'b0;
        ir_we     = 1'b0;
        mdr_we    = 1'b0;
        alu_src_b = 1'b0;
        alu_sub   = 1'b0;
        aluout_we = 1'b0;
        imm_sel   = ImmI;
        reg_we    = 1'b0;
        wb_sel    = 1'b0;
        pc_we     = 1'b0;
        pc_sel    = 1'b0;
        retire    = 1'b0;
        halted    = 1'b0;
        fault     = fault_q;

        unique case (state_q)
            StFetch: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    ir_we   = 1'b1;
                    state_d = StDecode;
                end else if (timeout) begin
                    state_d = StHalt;
                    fault_d = FaultTimeout;
                end
            end
            StDecode: begin
                if (is_addi || is_lw || is_sw) begin
                    state_d = StExec;
                end else if (is_beq) begin
                    state_d = StBranch;
                end else begin
                    state_d = StHalt;
                    fault_d = FaultIllegal;
                end
            end
            StExec: begin
                alu_src_b = 1'b1;
                aluout_we = 1'b1;
                imm_sel   = is_sw ? ImmS : ImmI;
                state_d   = is_addi ? StWb : StMem;
            end
            StMem: begin
                mem_req  = 1'b1;
                addr_sel = 1'b1;
                mem_we   = is_sw;
                if (mem_ready) begin
                    if (is_sw) begin
                        pc_we   = 1'b1;
                        retire  = 1'b1;
                        state_d = StFetch;
                    end else begin
                        mdr_we  = 1'b1;
                        state_d = StWb;
                    end
                end else if (timeout) begin
                    state_d = StHalt;
                    fault_d = FaultTimeout;
                end
            end
            StWb: begin
                reg_we  = (instr[11:7] != 5'd0);
                wb_sel  = is_lw;
                pc_we   = 1'b1;
                retire  = 1'b1;
                state_d = StFetch;
            end
            StBranch: begin
                alu_sub = 1'b1;
                imm_sel = ImmB;
                pc_we   = 1'b1;
                pc_sel  = alu_zero;
                retire  = 1'b1;
                state_d = StFetch;
            end
            StHalt: begin
                halted = 1'b1;
            end
            default: begin
                state_d = StFetch;
            end
        endcase

        // Counter restarts on every state change (entry to FETCH/MEM) and on any ready.
        if ((state_d != state_q) || mem_ready) begin
            cnt_d = '0;
        end else if (in_access) begin
            cnt_d = cnt_q + 8'd1;
        end else begin
            cnt_d = cnt_q;
        end

        // The state register sits in FETCH during reset; keep the port quiet until release.
        if (!rst_n) begin
            mem_req   = 1'b0;
            mem_we    = 1'b0;
            addr_sel  = 1'b0;
            ir_we     = 1'b0;
            mdr_we    = 1'b0;
            alu_src_b = 1'b0;
            alu_sub   = 1'b0;
            aluout_we = 1'b0;
            imm_sel   = 2'd0;
            reg_we    = 1'b0;
            wb_sel    = 1'b0;
            pc_we     = 1'b0;
            pc_sel    = 1'b0;
            retire    = 1'b0;
            halted    = 1'b0;
            fault     = 2'd0;
        end
    end

endmodule

// File: tb/tb_cpu_ctrl_fsm.sv
// Self-checking bench for cpu_ctrl_fsm (MEM_TIMEOUT = 4).
// A table of per-cycle {inputs, expected outputs} rows is walked in order; each row pushes
// its expected output vector into a scoreboard queue which is popped and compared at the
// following negedge. A hand-written sequence covers asynchronous reset mid-access.
module tb_cpu_ctrl_fsm;

    typedef struct packed {
        logic       mem_req;
        logic       mem_we;
        logic       addr_sel;
        logic       ir_we;
        logic       mdr_we;
        logic       alu_src_b;
        logic       alu_sub;
        logic       aluout_we;
        logic [1:0] imm_sel;
        logic       reg_we;
        logic       wb_sel;
        logic       pc_we;
        logic       pc_sel;
        logic       retire;
        logic       halted;
        logic [1:0] fault;
    } out_t;

    typedef struct {
        string       name;
        bit          do_reset;
        logic [31:0] instr;
        logic        alu_zero;
        logic        mem_ready;
        out_t        exp;
    } vec_t;

    localparam logic [31:0] IAddi5 = 32'h0070_0293; // addi x5, x0, 7
    localparam logic [31:0] IAddi0 = 32'h0070_0013; // addi x0, x0, 7
    localparam logic [31:0] ILw    = 32'h0042_A303; // lw   x6, 4(x5)
    localparam logic [31:0] ISw    = 32'h0062_A423; // sw   x6, 8(x5)
    localparam logic [31:0] IBeq   = 32'h0020_8063; // beq  x1, x2, 0
    localparam logic [31:0] ILb    = 32'h0002_8303; // lb: load opcode, unsupported funct3
    localparam logic [31:0] IRtype = 32'h0000_0033; // add: R-type

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] instr;
    logic        alu_zero;
    logic        mem_ready;
    logic        mem_req, mem_we, addr_sel, ir_we, mdr_we, alu_src_b, alu_sub, aluout_we;
    logic [1:0]  imm_sel;
    logic        reg_we, wb_sel, pc_we, pc_sel, retire, halted;
    logic [1:0]  fault;
    out_t        act;

    out_t sb[$];
    vec_t vecs[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    cpu_ctrl_fsm #(
        .MEM_TIMEOUT (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .instr     (instr),
        .alu_zero  (alu_zero),
        .mem_ready (mem_ready),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .addr_sel  (addr_sel),
        .ir_we     (ir_we),
        .mdr_we    (mdr_we),
        .alu_src_b (alu_src_b),
        .alu_sub   (alu_sub),
        .aluout_we (aluout_we),
        .imm_sel   (imm_sel),
        .reg_we    (reg_we),
        .wb_sel    (wb_sel),
        .pc_we     (pc_we),
        .pc_sel    (pc_sel),
        .retire    (retire),
        .halted    (halted),
        .fault     (fault)
    );

    assign act = {mem_req, mem_we, addr_sel, ir_we, mdr_we, alu_src_b, alu_sub, aluout_we,
                  imm_sel, reg_we, wb_sel, pc_we, pc_sel, retire, halted, fault};

    // Expected output vectors, one per state.
    function automatic out_t o_fetch(input logic rdy);
        out_t o = '0;
        o.mem_req = 1'b1;
        o.ir_we   = rdy;
        return o;
    endfunction

    function automatic out_t o_exec(input logic [1:0] imm);
        out_t o = '0;
        o.alu_src_b = 1'b1;
        o.aluout_we = 1'b1;
        o.imm_sel   = imm;
        return o;
    endfunction

    function automatic out_t o_mem(input logic sw, input logic rdy);
        out_t o = '0;
        o.mem_req  = 1'b1;
        o.addr_sel = 1'b1;
        o.mem_we   = sw;
        o.mdr_we   = rdy && !sw;
        o.pc_we    = rdy && sw;
        o.retire   = rdy && sw;
        return o;
    endfunction

    function automatic out_t o_wb(input logic rwe, input logic wsel);
        out_t o = '0;
        o.reg_we = rwe;
        o.wb_sel = wsel;
        o.pc_we  = 1'b1;
        o.retire = 1'b1;
        return o;
    endfunction

    function automatic out_t o_br(input logic z);
        out_t o = '0;
        o.alu_sub = 1'b1;
        o.imm_sel = 2'd2;
        o.pc_we   = 1'b1;
        o.pc_sel  = z;
        o.retire  = 1'b1;
        return o;
    endfunction

    function automatic out_t o_halt(input logic [1:0] f);
        out_t o = '0;
        o.halted = 1'b1;
        o.fault  = f;
        return o;
    endfunction

    task automatic add(input string n, input bit r, input logic [31:0] i, input logic az,
                       input logic rdy, input out_t e);
        vec_t v;
        v.name      = n;
        v.do_reset  = r;
        v.instr     = i;
        v.alu_zero  = az;
        v.mem_ready = rdy;
        v.exp       = e;
        vecs.push_back(v);
    endtask

    task automatic check(input string name);
        out_t e;
        e = sb.pop_front();
        n_tests++;
        if (act !== e) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", name, act, e);
        end
    endtask

    task automatic expect_now(input string name, input out_t e);
        sb.push_back(e);
        check(name);
    endtask

    // Called at posedge+1; drives one cycle, compares at negedge, returns at next posedge+1.
    task automatic step(input string name, input logic [31:0] i, input logic az,
                        input logic rdy, input out_t e);
        instr     = i;
        alu_zero  = az;
        mem_ready = rdy;
        sb.push_back(e);
        @(negedge clk);
        check(name);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        mem_ready = 1'b0;
        #1;
        expect_now("reset_zero", '0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n     = 1'b1;
        instr     = '0;
        alu_zero  = 1'b0;
        mem_ready = 1'b0;

        // ADDI x5, ready tied high (including DECODE/EXEC/WB, where it is ignored)
        add("addi_fetch",  1, IAddi5, 0, 1, o_fetch(1));
        add("addi_decode", 0, IAddi5, 0, 1, '0);
        add("addi_exec",   0, IAddi5, 0, 1, o_exec(2'd0));
        add("addi_wb",     0, IAddi5, 0, 1, o_wb(1, 0));
        // LW with 3 wait cycles in MEM; ready lands on the terminal count
        add("lw_fetch",    0, ILw, 0, 1, o_fetch(1));
        add("lw_decode",   0, ILw, 0, 0, '0);
        add("lw_exec",     0, ILw, 0, 0, o_exec(2'd0));
        for (int k = 0; k < 3; k++) add("lw_mem_wait", 0, ILw, 0, 0, o_mem(0, 0));
        add("lw_mem_rdy",  0, ILw, 0, 1, o_mem(0, 1));
        add("lw_wb",       0, ILw, 0, 0, o_wb(1, 1));
        // SW with one wait cycle
        add("sw_fetch",    0, ISw, 0, 1, o_fetch(1));
        add("sw_decode",   0, ISw, 0, 0, '0);
        add("sw_exec",     0, ISw, 0, 0, o_exec(2'd1));
        add("sw_mem_wait", 0, ISw, 0, 0, o_mem(1, 0));
        add("sw_mem_rdy",  0, ISw, 0, 1, o_mem(1, 1));
        // BEQ taken then not taken
        add("beq1_fetch",  0, IBeq, 1, 1, o_fetch(1));
        add("beq1_decode", 0, IBeq, 1, 0, '0);
        add("beq1_branch", 0, IBeq, 1, 0, o_br(1));
        add("beq0_fetch",  0, IBeq, 0, 1, o_fetch(1));
        add("beq0_decode", 0, IBeq, 0, 0, '0);
        add("beq0_branch", 0, IBeq, 0, 0, o_br(0));
        // ADDI rd=0: no register write, still retires
        add("addi0_fetch", 0, IAddi0, 0, 1, o_fetch(1));
        add("addi0_decode",0, IAddi0, 0, 0, '0);
        add("addi0_exec",  0, IAddi0, 0, 0, o_exec(2'd0));
        add("addi0_wb",    0, IAddi0, 0, 0, o_wb(0, 0));
        // Fetch ready on the 4th request cycle wins over the timeout
        for (int k = 0; k < 3; k++) add("fetch_wait", 0, IAddi5, 0, 0, o_fetch(0));
        add("fetch_rdy_term", 0, IAddi5, 0, 1, o_fetch(1));
        add("late_decode",    0, IAddi5, 0, 0, '0);
        add("late_exec",      0, IAddi5, 0, 0, o_exec(2'd0));
        add("late_wb",        0, IAddi5, 0, 0, o_wb(1, 0));
        // Load opcode with wrong funct3 is illegal
        add("lb_fetch",    0, ILb, 0, 1, o_fetch(1));
        add("lb_decode",   0, ILb, 0, 0, '0);
        for (int k = 0; k < 3; k++) add("lb_halt", 0, ILb, 0, 1, o_halt(2'd1));
        // R-type illegal after reset: halt is sticky, no requests for 20 cycles
        add("rtype_fetch", 1, IRtype, 0, 1, o_fetch(1));
        add("rtype_decode",0, IRtype, 0, 0, '0);
        for (int k = 0; k < 20; k++) add("rtype_halt", 0, IRtype, 0, k[0], o_halt(2'd1));
        // Fetch timeout: 4 request cycles then HALT with no IR write
        for (int k = 0; k < 4; k++) add("fetch_to_wait", (k == 0), IAddi5, 0, 0, o_fetch(0));
        for (int k = 0; k < 3; k++) add("fetch_to_halt", 0, IAddi5, 0, k[0], o_halt(2'd2));
        // MEM timeout on LW: no MDR write
        add("lwto_fetch",  1, ILw, 0, 1, o_fetch(1));
        add("lwto_decode", 0, ILw, 0, 0, '0);
        add("lwto_exec",   0, ILw, 0, 0, o_exec(2'd0));
        for (int k = 0; k < 4; k++) add("lwto_mem_wait", 0, ILw, 0, 0, o_mem(0, 0));
        add("lwto_halt",   0, ILw, 0, 0, o_halt(2'd2));
        add("lwto_halt",   0, ILw, 0, 1, o_halt(2'd2));

        #2;
        do_reset();
        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].do_reset) do_reset();
            step(vecs[i].name, vecs[i].instr, vecs[i].alu_zero, vecs[i].mem_ready,
                 vecs[i].exp);
        end

        // Reset asserted mid-wait drops the request at once; the counter restarts afterwards
        do_reset();
        step("mid_wait_1", IAddi5, 0, 0, o_fetch(0));
        step("mid_wait_2", IAddi5, 0, 0, o_fetch(0));
        #3;
        rst_n = 1'b0;
        #1;
        expect_now("async_rst_drop", '0);
        @(posedge clk);
        #1;
        expect_now("async_rst_hold", '0);
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) step("post_rst_wait", IAddi5, 0, 0, o_fetch(0));
        step("post_rst_halt", IAddi5, 0, 0, o_halt(2'd2));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
